// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the data-memory responder: bus word, RAM handshake state,
// responder FSM state and the error word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, REQ, DONE} dmem_state_t;

  localparam word_t DMEM_BAD_WORD = 32'hBAD1BAD1;

  // LL/SC reservations are tracked per 32-bit word.
  function automatic logic [29:0] wordAddr(input word_t a);
    return a[31:2];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline MEM-stage request port and shared RAM port of dmem_responder.
// datomic exists only when DMEM_LLSC_EN is defined.
interface dmem_responder_if;
  import cpu_types_pkg::*;

  // Pipeline side: dREN/dWEN is held until dhit pulses for one cycle, and must
  // drop or change in the cycle after dhit. RAM side: strobes stay high until
  // ramstate reports ACCESS or ERROR.
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
`ifdef DMEM_LLSC_EN
  logic      datomic;
`endif
  logic      dhit;
  word_t     dload;
  logic      derr;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
`ifdef DMEM_LLSC_EN
    input  datomic,
`endif
    input  dREN, dWEN, daddr, dstore, ramload, ramstate,
    output dhit, dload, derr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
`ifdef DMEM_LLSC_EN
    output datomic,
`endif
    output dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  dhit, dload, derr, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/dmem_responder_link_reg.sv
// Load-linked reservation register (valid bit + word address); only built
// when DMEM_LLSC_EN is defined.
`ifdef DMEM_LLSC_EN
module dmem_link_reg (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set,
  input  logic        clr,
  input  logic [29:0] setAddr,
  input  logic [29:0] cmpAddr,
  output logic        match
);

  logic        linkValid;
  logic [29:0] linkAddr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      linkValid <= 1'b0;
      linkAddr  <= '0;
    end else if (clr) begin
      linkValid <= 1'b0;
    end else if (set) begin
      linkValid <= 1'b1;
      linkAddr  <= setAddr;
    end
  end

  assign match = linkValid && (linkAddr == cmpAddr);

endmodule
`endif

// File: rtl/dmem_responder.sv
// MEM-stage data responder: turns the multi-cycle RAM ramstate handshake into a
// single dhit pulse, with a REQ timeout. DMEM_LLSC_EN adds LL/SC support.
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT_CYC = 15,
  parameter word_t BAD_WORD    = DMEM_BAD_WORD
) (
  input  logic             CLK,
  input  logic             nRST,
  dmem_responder_if.slave  dif,
  output dmem_state_t      dbgState
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  dmem_state_t   state;
  logic [CW-1:0] toCnt;
  logic          opWrite;
  logic          dhitQ, derrQ, ramRenQ, ramWenQ;
  word_t         dloadQ, ramAddrQ, ramStoreQ;
  word_t         writeResult;
  logic          ramDone, ramFail;

  assign ramDone = (dif.ramstate == ACCESS);
  assign ramFail = (dif.ramstate == ERROR) || (toCnt == CW'(TIMEOUT_CYC));

`ifdef DMEM_LLSC_EN
  logic opAtomic;
  logic linkSet, linkClr, linkMatch, scFail;

  // LL reserves only once the read has actually completed; SC success or a
  // plain store to the reserved word drops the reservation.
  assign linkSet = (state == REQ) && !opWrite && opAtomic && ramDone;
  assign linkClr = ((state == REQ) && opWrite && opAtomic && ramDone) ||
                   ((state == IDLE) && dif.dWEN && !dif.datomic && linkMatch);
  assign scFail  = dif.dWEN && dif.datomic && !linkMatch;
  assign writeResult = {31'b0, opAtomic};

  dmem_link_reg u_link (
    .CLK     (CLK),
    .nRST    (nRST),
    .set     (linkSet),
    .clr     (linkClr),
    .setAddr (wordAddr(ramAddrQ)),
    .cmpAddr (wordAddr(dif.daddr)),
    .match   (linkMatch)
  );
`else
  assign writeResult = '0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      toCnt     <= '0;
      opWrite   <= 1'b0;
`ifdef DMEM_LLSC_EN
      opAtomic  <= 1'b0;
`endif
      dhitQ     <= 1'b0;
      derrQ     <= 1'b0;
      dloadQ    <= '0;
      ramRenQ   <= 1'b0;
      ramWenQ   <= 1'b0;
      ramAddrQ  <= '0;
      ramStoreQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          toCnt <= '0;
          if (dif.dWEN || dif.dREN) begin
            ramAddrQ  <= dif.daddr;
            ramStoreQ <= dif.dstore;
            opWrite   <= dif.dWEN;
`ifdef DMEM_LLSC_EN
            opAtomic  <= dif.datomic;
            // A failing SC never touches the RAM.
            if (scFail) begin
              state  <= DONE;
              dhitQ  <= 1'b1;
              dloadQ <= '0;
              derrQ  <= 1'b0;
            end else
`endif
            begin
              state   <= REQ;
              ramWenQ <= dif.dWEN;
              ramRenQ <= !dif.dWEN;
            end
          end
        end
        REQ: begin
          if (ramDone) begin
            state   <= DONE;
            dhitQ   <= 1'b1;
            dloadQ  <= opWrite ? writeResult : dif.ramload;
            derrQ   <= 1'b0;
            toCnt   <= '0;
            ramRenQ <= 1'b0;
            ramWenQ <= 1'b0;
          end else if (ramFail) begin
            state   <= DONE;
            dhitQ   <= 1'b1;
            dloadQ  <= BAD_WORD;
            derrQ   <= 1'b1;
            toCnt   <= '0;
            ramRenQ <= 1'b0;
            ramWenQ <= 1'b0;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        DONE: begin
          dhitQ <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          dhitQ   <= 1'b0;
          ramRenQ <= 1'b0;
          ramWenQ <= 1'b0;
        end
      endcase
    end
  end

  assign dif.dhit     = dhitQ;
  assign dif.dload    = dloadQ;
  assign dif.derr     = derrQ;
  assign dif.ramREN   = ramRenQ;
  assign dif.ramWEN   = ramWenQ;
  assign dif.ramaddr  = ramAddrQ;
  assign dif.ramstore = ramStoreQ;
  assign dbgState     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (TIMEOUT_CYC=4); LL/SC cases run when
// DMEM_LLSC_EN is defined.
module tb_dmem_responder;
  import cpu_types_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if dif();
  dmem_state_t dbg_state;

  dmem_responder #(.TIMEOUT_CYC(4), .BAD_WORD(32'hBAD1BAD1)) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .dif      (dif),
    .dbgState (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];  // {derr, dload}

  int    ram_wait = 0;
  logic  ram_err = 1'b0;
  logic  ram_stuck = 1'b0;
  int    busy_cnt = 0;
  int    ren_cyc = 0;
  int    wen_cyc = 0;
  int    bus_bad = 0;
  word_t exp_addr = '0;
  word_t exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // RAM model: answers BUSY for ram_wait strobed cycles, then ACCESS or ERROR.
  always @(negedge clk) begin
    if (dif.ramREN === 1'b1 || dif.ramWEN === 1'b1) begin
      if (dif.ramREN) ren_cyc++;
      if (dif.ramWEN) wen_cyc++;
      if (dif.ramaddr !== exp_addr || (dif.ramWEN && dif.ramstore !== exp_data)) bus_bad++;
      if (ram_stuck || busy_cnt < ram_wait) begin
        dif.ramstate = BUSY;
        busy_cnt++;
      end else begin
        dif.ramstate = ram_err ? ERROR : ACCESS;
      end
    end else begin
      dif.ramstate = FREE;
      busy_cnt = 0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (nrst && dif.dhit === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dhit actual=1 expected=0 at %0t", $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("dload", dif.dload, e[31:0]);
        check("derr", {31'b0, dif.derr}, {31'b0, e[32]});
      end
    end
  end

  // driver
  task automatic do_access(input string name, input logic ren, input logic wen,
                           input logic atom, input word_t addr, input word_t data,
                           input int wt, input logic err, input logic stuck,
                           input logic [32:0] expv, input int exp_lat,
                           input int exp_ren, input int exp_wen);
    int lat;
    bit hit;
    ram_wait = wt; ram_err = err; ram_stuck = stuck;
    ren_cyc = 0; wen_cyc = 0; bus_bad = 0;
    exp_addr = addr; exp_data = data;
    exp_q.push_back(expv);
    dif.dREN = ren; dif.dWEN = wen; dif.daddr = addr; dif.dstore = data;
`ifdef DMEM_LLSC_EN
    dif.datomic = atom;
`endif
    lat = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dif.dhit === 1'b1) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s_no_dhit actual=none expected=dhit within 40 cycles", name);
      exp_q.delete();
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_strobes_at_hit"}, {30'b0, dif.ramREN, dif.ramWEN}, 32'd0);
    end
    dif.dREN = 1'b0; dif.dWEN = 1'b0;
`ifdef DMEM_LLSC_EN
    dif.datomic = 1'b0;
`endif
    ram_stuck = 1'b0; ram_err = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({name, "_ramREN_cycles"}, 32'(ren_cyc), 32'(exp_ren));
    check({name, "_ramWEN_cycles"}, 32'(wen_cyc), 32'(exp_wen));
    check({name, "_bus_stable"}, 32'(bus_bad), 32'd0);
    if (atom) check({name, "_idle_after"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    dif.dREN = 1'b0; dif.dWEN = 1'b0; dif.daddr = '0; dif.dstore = '0;
`ifdef DMEM_LLSC_EN
    dif.datomic = 1'b0;
`endif
    dif.ramload = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dhit", {31'b0, dif.dhit}, 32'd0);
    check("rst_derr", {31'b0, dif.derr}, 32'd0);
    check("rst_dload", dif.dload, 32'd0);
    check("rst_strobes", {30'b0, dif.ramREN, dif.ramWEN}, 32'd0);
    check("rst_ramaddr", dif.ramaddr, 32'd0);
    check("rst_ramstore", dif.ramstore, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    nrst = 1'b1;
    @(posedge clk); #1;

    dif.ramload = 32'hCAFEF00D;
    do_access("load0", 1, 0, 0, 32'h40, 32'h0, 0, 0, 0, {1'b0, 32'hCAFEF00D}, 2, 1, 0);
    dif.ramload = 32'hDEADBEEF;
    do_access("store_busy", 0, 1, 0, 32'h80, 32'h12345678, 3, 0, 0, {1'b0, 32'h0}, 5, 0, 4);
    do_access("load_err", 1, 0, 0, 32'h44, 32'h0, 1, 1, 0, {1'b1, 32'hBAD1BAD1}, 3, 2, 0);
    do_access("timeout", 1, 0, 0, 32'h48, 32'h0, 0, 0, 1, {1'b1, 32'hBAD1BAD1}, 6, 5, 0);
    do_access("dual", 1, 1, 0, 32'h200, 32'h55AA55AA, 0, 0, 0, {1'b0, 32'h0}, 2, 0, 1);
    dif.ramload = 32'h0BADF00D;
    do_access("load_busy2", 1, 0, 0, 32'hFFFFFFFC, 32'h0, 2, 0, 0, {1'b0, 32'h0BADF00D}, 4, 3, 0);

    // reset while in REQ: strobes must fall immediately and no dhit follows
    ram_stuck = 1'b1; exp_addr = 32'h300;
    dif.dREN = 1'b1; dif.daddr = 32'h300;
    @(posedge clk); #1;
    check("midreq_ren_high", {31'b0, dif.ramREN}, 32'd1);
    @(posedge clk); #2;
    nrst = 1'b0;
    #1;
    check("midreq_strobes", {30'b0, dif.ramREN, dif.ramWEN}, 32'd0);
    check("midreq_dhit", {31'b0, dif.dhit}, 32'd0);
    check("midreq_state", 32'(dbg_state), 32'(IDLE));
    dif.dREN = 1'b0; ram_stuck = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midreq_no_dhit_after", {31'b0, dif.dhit}, 32'd0);

`ifdef DMEM_LLSC_EN
    dif.ramload = 32'h11112222;
    do_access("ll", 1, 0, 1, 32'h100, 32'h0, 0, 0, 0, {1'b0, 32'h11112222}, 2, 1, 0);
    do_access("sc_ok", 0, 1, 1, 32'h100, 32'hA5A5A5A5, 0, 0, 0, {1'b0, 32'h1}, 2, 0, 1);
    do_access("sc_again", 0, 1, 1, 32'h100, 32'hA5A5A5A5, 0, 0, 0, {1'b0, 32'h0}, 1, 0, 0);
    do_access("ll2", 1, 0, 1, 32'h100, 32'h0, 0, 0, 0, {1'b0, 32'h11112222}, 2, 1, 0);
    do_access("plain_st", 0, 1, 0, 32'h100, 32'h77777777, 0, 0, 0, {1'b0, 32'h0}, 2, 0, 1);
    do_access("sc_broken", 0, 1, 1, 32'h100, 32'h99999999, 0, 0, 0, {1'b0, 32'h0}, 1, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
